risac_mem_arbiter: RTL

Shares one single-ported, pipelined memory slave between the core's instruction bus and data bus. It sits between the core's fetch/LSU ports and the on-chip memory. It serialises requests, holds the core's wait signals until each access completes, and returns read data together with the address it came from. Data-bus accesses have priority, and a bounded starvation counter guarantees fetch progress.

---
 rtl/risac_pkg.sv | 15 +
 rtl/risac_mem_arbiter_if.sv | 44 ++++
 rtl/risac_mem_arbiter.sv | 113 +++++++++++
 3 files changed

// File: rtl/risac_pkg.sv
// Shared types and constants for the risac memory arbiter.
package risac_pkg;

    localparam int unsigned RISAC_XLEN = 32;
    localparam logic [3:0] RISAC_BE_FULL = 4'b1111;

    typedef enum logic [2:0] {
        StIdle,
        StIReq,
        StIData,
        StDReq,
        StDData
    } arbState_e;

endpackage

// File: rtl/risac_mem_arbiter_if.sv
// Bundle of fetch, load/store and memory-slave signals seen by the arbiter.
interface risac_mem_arbiter_if;
    import risac_pkg::*;

    logic [RISAC_XLEN-1:0] iIbusAddr;
    logic                  iIbusRead;
    logic [RISAC_XLEN-1:0] oIbusData;
    logic [RISAC_XLEN-1:0] oIbusIAddr;
    logic                  oIbusWait;

    logic [RISAC_XLEN-1:0] iDbusAddr;
    logic                  iDbusRead;
    logic                  iDbusWe;
    logic [RISAC_XLEN-1:0] iDbusData;
    logic [3:0]            iDbusByteEn;
    logic [RISAC_XLEN-1:0] oDbusData;
    logic                  oDbusWait;

    logic [RISAC_XLEN-1:0] oMemAddr;
    logic                  oMemRead;
    logic                  oMemWrite;
    logic [RISAC_XLEN-1:0] oMemData;
    logic [3:0]            oMemByteEn;
    logic                  iMemWait;
    logic [RISAC_XLEN-1:0] iMemData;
    logic                  iMemValid;

    // Arbiter side.
    modport slave (
        input  iIbusAddr, iIbusRead, iDbusAddr, iDbusRead, iDbusWe, iDbusData, iDbusByteEn,
        input  iMemWait, iMemData, iMemValid,
        output oIbusData, oIbusIAddr, oIbusWait, oDbusData, oDbusWait,
        output oMemAddr, oMemRead, oMemWrite, oMemData, oMemByteEn
    );

    // Core / memory side.
    modport master (
        output iIbusAddr, iIbusRead, iDbusAddr, iDbusRead, iDbusWe, iDbusData, iDbusByteEn,
        output iMemWait, iMemData, iMemValid,
        input  oIbusData, oIbusIAddr, oIbusWait, oDbusData, oDbusWait,
        input  oMemAddr, oMemRead, oMemWrite, oMemData, oMemByteEn
    );

endinterface

// File: rtl/risac_mem_arbiter.sv
// Arbitrates the instruction and data buses onto one pipelined memory slave.
// Dbus has priority; a starvation counter forces an ibus grant after STARVE_MAX dbus grants.
module risac_mem_arbiter
    import risac_pkg::*;
#(
    parameter int unsigned STARVE_MAX = 4
) (
    input logic                clk,
    input logic                rst,
    risac_mem_arbiter_if.slave bus
);

    localparam logic [3:0] StarveMax = 4'(STARVE_MAX);

    arbState_e             state, stateNext;
    logic [3:0]            starveCnt;
    logic [RISAC_XLEN-1:0] memAddr, memData, ibusIAddr;
    logic [3:0]            memByteEn;
    logic                  memRead, memWrite;

    logic iReq, dReq, grantI, grantD, memAccept, ibusDone, dbusDone;

    assign iReq      = bus.iIbusRead;
    assign dReq      = bus.iDbusRead | bus.iDbusWe;
    assign memAccept = ~bus.iMemWait;
    assign grantI    = (state == StIdle) && iReq && (!dReq || starveCnt == StarveMax);
    assign grantD    = (state == StIdle) && dReq && !grantI;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= StIdle;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext = state;
        unique case (state)
            StIdle: begin
                if (grantD) begin
                    stateNext = StDReq;
                end else if (grantI) begin
                    stateNext = StIReq;
                end
            end
            StIReq:  if (memAccept) stateNext = StIData;
            StIData: if (bus.iMemValid) stateNext = StIdle;
            StDReq:  if (memAccept) stateNext = memWrite ? StIdle : StDData;
            StDData: if (bus.iMemValid) stateNext = StIdle;
            default: stateNext = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            memAddr   <= '0;
            memData   <= '0;
            memByteEn <= '0;
            memRead   <= 1'b0;
            memWrite  <= 1'b0;
            ibusIAddr <= '0;
        end else if (grantD) begin
            // A combined read+write request is treated as a store.
            memAddr   <= bus.iDbusAddr;
            memData   <= bus.iDbusData;
            memByteEn <= bus.iDbusByteEn;
            memWrite  <= bus.iDbusWe;
            memRead   <= ~bus.iDbusWe;
        end else if (grantI) begin
            memAddr   <= bus.iIbusAddr;
            memData   <= '0;
            memByteEn <= RISAC_BE_FULL;
            memWrite  <= 1'b0;
            memRead   <= 1'b1;
            ibusIAddr <= bus.iIbusAddr;
        end else if ((state == StIReq || state == StDReq) && memAccept) begin
            memRead  <= 1'b0;
            memWrite <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || grantI) begin
            starveCnt <= '0;
        end else if (grantD) begin
            if (!iReq) begin
                starveCnt <= '0;
            end else if (starveCnt != StarveMax) begin
                starveCnt <= starveCnt + 4'd1;
            end
        end
    end

    always_comb begin
        // Gated by rst so the wait outputs mirror the requests while in reset.
        ibusDone = !rst && (state == StIData) && bus.iMemValid;
        dbusDone = !rst && (((state == StDReq) && memWrite && memAccept) ||
                            ((state == StDData) && bus.iMemValid));

        bus.oIbusWait  = iReq & ~ibusDone;
        bus.oDbusWait  = dReq & ~dbusDone;
        bus.oIbusData  = ibusDone ? bus.iMemData : '0;
        bus.oDbusData  = dbusDone ? bus.iMemData : '0;
        bus.oIbusIAddr = ibusIAddr;
        bus.oMemAddr   = memAddr;
        bus.oMemRead   = memRead;
        bus.oMemWrite  = memWrite;
        bus.oMemData   = memData;
        bus.oMemByteEn = memByteEn;
    end

endmodule
